// File: rtl/display_scan_controller.sv
// Four-digit seven-segment scan scheduler: per-digit slots with a blanked guard
// window, a per-frame shadow of the displayed value, and leading-zero blanking.
module display_scan_controller #(
    parameter int CLK_DIV = 100000,
    parameter int GUARD   = 2000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable_i,
    input  logic [15:0] value_i,
    input  logic        lz_blank_i,
    output logic [1:0]  sel_o,
    output logic [3:0]  an_o,
    output logic [3:0]  nibble_o,
    output logic        frame_o
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GUARD_LAST = (GUARD > 0) ? CW'(GUARD - 1) : '0;

    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_GUARD = 2'd1,
        S_ON    = 2'd2
    } state_t;

    localparam state_t SLOT_START = (GUARD == 0) ? S_ON : S_GUARD;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      sel_q, sel_d;
    logic [15:0]     shadow_q, shadow_d;
    logic            lz_q, lz_d;
    logic            blank;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_OFF;
            cnt_q    <= '0;
            sel_q    <= 2'd0;
            shadow_q <= 16'h0000;
            lz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            shadow_q <= shadow_d;
            lz_q     <= lz_d;
        end
    end

    // The blanking mode is captured alongside the shadow so that no input
    // reaches the outputs combinationally and a frame never changes mid-scan.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        shadow_d = shadow_q;
        lz_d     = lz_q;
        if (!enable_i) begin
            state_d = S_OFF;
            cnt_d   = '0;
            sel_d   = 2'd0;
        end else begin
            case (state_q)
                S_OFF: begin
                    shadow_d = value_i;
                    lz_d     = lz_blank_i;
                    cnt_d    = '0;
                    sel_d    = 2'd0;
                    state_d  = SLOT_START;
                end
                S_GUARD, S_ON: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        sel_d   = sel_q + 2'd1;
                        state_d = SLOT_START;
                        if (sel_q == 2'd3) begin
                            shadow_d = value_i;
                            lz_d     = lz_blank_i;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        if (state_q == S_GUARD && cnt_q == GUARD_LAST) begin
                            state_d = S_ON;
                        end
                    end
                end
                default: begin
                    state_d = S_OFF;
                    cnt_d   = '0;
                    sel_d   = 2'd0;
                end
            endcase
        end
    end

    // Digit k is blanked when it and every more-significant digit are zero.
    always_comb begin
        blank = 1'b0;
        if (lz_q) begin
            case (sel_q)
                2'd1:    blank = (shadow_q[15:4] == 12'h000);
                2'd2:    blank = (shadow_q[15:8] == 8'h00);
                2'd3:    blank = (shadow_q[15:12] == 4'h0);
                default: blank = 1'b0;
            endcase
        end
    end

    assign sel_o    = sel_q;
    assign nibble_o = shadow_q[{sel_q, 2'b00} +: 4];
    assign an_o     = (state_q == S_ON && !blank) ? ~(4'b0001 << sel_q) : 4'b1111;
    assign frame_o  = (state_q != S_OFF) && (sel_q == 2'd3) && (cnt_q == CNT_LAST);

endmodule
